// File: rtl/mem_stage_top.sv
// MEM stage of a 5-stage MIPS pipeline: EX/MEM latch, word-addressed data memory
// with configurable access latency, branch resolution and the MEM/WB latch.
module mem_stage_top #(
  parameter int ADDR_W        = 8,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_ctlout,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] EX_MEM_NPC,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic [1:0]  mem_wb_ctl,
  output logic [31:0] mem_rdata,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_wb_dst,
  output logic        misaligned
);

  localparam bit MULTI = (ACCESS_CYCLES > 1);
  localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((ACCESS_CYCLES > 1) ? ACCESS_CYCLES - 2 : 0);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]  exm_wb_q;
  logic        exm_branch_q, exm_rd_q, exm_wr_q, exm_zero_q;
  logic [31:0] exm_npc_q, exm_alu_q, exm_wdata_q;
  logic [4:0]  exm_dst_q;

  logic [1:0]  mwb_ctl_q;
  logic [31:0] mwb_rdata_q, mwb_alu_q;
  logic [4:0]  mwb_dst_q;
  logic        mwb_mis_q;

  logic [31:0] mem_q [2**ADDR_W];

  logic              mem_req, aligned, access, mis_req, stall_c;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rdata_d;

  assign mem_req = exm_rd_q | exm_wr_q;
  assign aligned = (exm_alu_q[1:0] == 2'b00);
  assign access  = mem_req & aligned;
  assign mis_req = mem_req & ~aligned;
  assign idx     = exm_alu_q[ADDR_W+1:2];

  // Handshake: stall=1 means the EX/MEM contents are still being worked on and
  // upstream must hold its outputs; an instruction is accepted on every rising
  // edge where stall=0 (and rst=0), which is also the edge that completes the
  // instruction currently in EX/MEM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && MULTI) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
          stall_c = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - CNT_W'(1);
          stall_c = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A simultaneous read and write is treated as a store only.
  always_comb begin
    rdata_d = '0;
    if (access && exm_rd_q && !exm_wr_q) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      exm_wb_q     <= '0;
      exm_branch_q <= 1'b0;
      exm_rd_q     <= 1'b0;
      exm_wr_q     <= 1'b0;
      exm_zero_q   <= 1'b0;
      exm_npc_q    <= '0;
      exm_alu_q    <= '0;
      exm_wdata_q  <= '0;
      exm_dst_q    <= '0;
      mwb_ctl_q    <= '0;
      mwb_rdata_q  <= '0;
      mwb_alu_q    <= '0;
      mwb_dst_q    <= '0;
      mwb_mis_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!stall_c) begin
        exm_wb_q     <= wb_ctlout;
        exm_branch_q <= branch;
        exm_rd_q     <= memread;
        exm_wr_q     <= memwrite;
        exm_zero_q   <= zero;
        exm_npc_q    <= EX_MEM_NPC;
        exm_alu_q    <= alu_result;
        exm_wdata_q  <= rdata2out;
        exm_dst_q    <= five_bit_muxout;
        mwb_ctl_q    <= exm_wb_q;
        mwb_rdata_q  <= rdata_d;
        mwb_alu_q    <= exm_alu_q;
        mwb_dst_q    <= exm_dst_q;
        mwb_mis_q    <= mis_req;
      end else begin
        mwb_ctl_q <= '0;
      end
    end
  end

  // Memory contents survive reset; a store aborted by reset is never written.
  always_ff @(posedge clk) begin
    if (!rst && !stall_c && access && exm_wr_q) mem_q[idx] <= exm_wdata_q;
  end

  assign stall          = stall_c;
  assign pcsrc          = exm_branch_q & exm_zero_q;
  assign branch_target  = exm_npc_q;
  assign mem_wb_ctl     = mwb_ctl_q;
  assign mem_rdata      = mwb_rdata_q;
  assign mem_alu_result = mwb_alu_q;
  assign mem_wb_dst     = mwb_dst_q;
  assign misaligned     = mwb_mis_q;

endmodule

// File: tb/tb_mem_stage_top.sv
// Bench for mem_stage_top: one single-cycle and one 3-cycle instance, driven
// one at a time, checked by a queue-based scoreboard against a word-array model.
module tb_mem_stage_top;

  localparam int AC_B = 3;

  typedef struct packed {
    logic [1:0]  wb;
    logic        branch;
    logic        rd;
    logic        wr;
    logic [31:0] npc;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  dst;
  } instr_t;

  typedef struct packed {
    logic [1:0]  ctl;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  dst;
    logic        mis;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  instr_t in_a, in_b;
  logic        stall_a, pcsrc_a, mis_a, stall_b, pcsrc_b, mis_b;
  logic [31:0] tgt_a, rdata_a, alu_a, tgt_b, rdata_b, alu_b;
  logic [1:0]  ctl_a, ctl_b;
  logic [4:0]  dst_a, dst_b;

  mem_stage_top #(.ADDR_W(8), .ACCESS_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .wb_ctlout(in_a.wb), .branch(in_a.branch),
    .memread(in_a.rd), .memwrite(in_a.wr), .EX_MEM_NPC(in_a.npc),
    .zero(in_a.zero), .alu_result(in_a.alu), .rdata2out(in_a.wdata),
    .five_bit_muxout(in_a.dst), .stall(stall_a), .pcsrc(pcsrc_a),
    .branch_target(tgt_a), .mem_wb_ctl(ctl_a), .mem_rdata(rdata_a),
    .mem_alu_result(alu_a), .mem_wb_dst(dst_a), .misaligned(mis_a)
  );

  mem_stage_top #(.ADDR_W(8), .ACCESS_CYCLES(AC_B)) dut_b (
    .clk(clk), .rst(rst), .wb_ctlout(in_b.wb), .branch(in_b.branch),
    .memread(in_b.rd), .memwrite(in_b.wr), .EX_MEM_NPC(in_b.npc),
    .zero(in_b.zero), .alu_result(in_b.alu), .rdata2out(in_b.wdata),
    .five_bit_muxout(in_b.dst), .stall(stall_b), .pcsrc(pcsrc_b),
    .branch_target(tgt_b), .mem_wb_ctl(ctl_b), .mem_rdata(rdata_b),
    .mem_alu_result(alu_b), .mem_wb_dst(dst_b), .misaligned(mis_b)
  );

  logic sel = 1'b0;
  logic        act_stall, act_pcsrc, act_mis;
  logic [31:0] act_tgt, act_rdata, act_alu;
  logic [1:0]  act_ctl;
  logic [4:0]  act_dst;

  assign act_stall = sel ? stall_b : stall_a;
  assign act_pcsrc = sel ? pcsrc_b : pcsrc_a;
  assign act_tgt   = sel ? tgt_b   : tgt_a;
  assign act_ctl   = sel ? ctl_b   : ctl_a;
  assign act_rdata = sel ? rdata_b : rdata_a;
  assign act_alu   = sel ? alu_b   : alu_a;
  assign act_dst   = sel ? dst_b   : dst_a;
  assign act_mis   = sel ? mis_b   : mis_a;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  exp_t        exp_q[$];
  exp_t        last_exp = '0;
  logic [31:0] model_mem [2][256];
  logic        exp_pcsrc = 1'b0;
  logic [31:0] exp_tgt = '0;
  logic        prev_acc = 1'b0;
  logic        prev_rst = 1'b1;
  logic        prev_stall = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t got, e;
    got = {act_ctl, act_rdata, act_alu, act_dst, act_mis};
    if (prev_rst) begin
      check("reset_out", 128'({got, act_stall, act_pcsrc, act_tgt}), 128'(0));
      last_exp = '0;
    end else if (!prev_stall) begin
      if (exp_q.size() == 0) begin
        check("queue_empty", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("mem_wb", 128'(got), 128'(e));
        last_exp = e;
      end
    end else begin
      e = last_exp;
      e.ctl = 2'b00;
      check("bubble", 128'(got), 128'(e));
    end
    if (!prev_rst) check("branch", 128'({act_pcsrc, act_tgt}), 128'({exp_pcsrc, exp_tgt}));
    prev_rst   = rst;
    prev_stall = act_stall;
  end

  // ---------------- driver tasks ----------------
  function automatic instr_t mk(input logic [1:0] wb, input logic br, input logic rd,
                                input logic wr, input logic [31:0] npc, input logic z,
                                input logic [31:0] alu, input logic [31:0] wdata,
                                input logic [4:0] dst);
    instr_t x;
    x.wb = wb; x.branch = br; x.rd = rd; x.wr = wr; x.npc = npc;
    x.zero = z; x.alu = alu; x.wdata = wdata; x.dst = dst;
    return x;
  endfunction

  function automatic instr_t rand_any();
    instr_t x;
    x.wb = 2'($urandom_range(0, 3)); x.branch = 1'($urandom_range(0, 1));
    x.rd = 1'($urandom_range(0, 1)); x.wr = 1'($urandom_range(0, 1));
    x.npc = $urandom; x.zero = 1'($urandom_range(0, 1)); x.alu = $urandom;
    x.wdata = $urandom; x.dst = 5'($urandom_range(0, 31));
    return x;
  endfunction

  // Addresses confined to words 0..15 (preloaded) with random upper bits.
  function automatic instr_t rand_instr();
    instr_t x;
    logic [31:0] r;
    int k;
    x = rand_any();
    k = $urandom_range(0, 7);
    x.rd = (k == 3) || (k == 4) || (k == 7);
    x.wr = (k == 5) || (k == 6) || (k == 7);
    r = $urandom;
    x.alu = {r[31:10], 4'b0000, r[5:2], 2'b00};
    if ($urandom_range(0, 3) == 0) x.alu[1:0] = r[1:0];
    return x;
  endfunction

  task automatic issue(input instr_t x);
    int waits, exp_w;
    exp_t e;
    logic mis, acc;
    logic [7:0] idx;
    if (sel) in_b = x; else in_a = x;
    waits = 0;
    @(negedge clk);
    while (act_stall && waits < 16) begin
      waits++;
      @(negedge clk);
    end
    exp_w = (prev_acc && sel) ? AC_B - 1 : 0;
    check("stall_cycles", 128'(waits), 128'(exp_w));
    mis = (x.rd || x.wr) && (x.alu[1:0] != 2'b00);
    acc = (x.rd || x.wr) && !mis;
    idx = x.alu[9:2];
    e.ctl = x.wb; e.alu = x.alu; e.dst = x.dst; e.mis = mis; e.rdata = '0;
    if (acc && x.wr) model_mem[sel][idx] = x.wdata;
    else if (acc && x.rd) e.rdata = model_mem[sel][idx];
    exp_q.push_back(e);
    @(posedge clk);
    exp_pcsrc = x.branch & x.zero;
    exp_tgt   = x.npc;
    prev_acc  = acc;
    #1;
  endtask

  task automatic do_reset(input logic new_sel);
    rst  = 1'b1;
    in_a = rand_any();
    in_b = rand_any();
    @(posedge clk); #1;
    sel = new_sel;
    exp_pcsrc = 1'b0;
    exp_tgt   = '0;
    @(posedge clk); #1;
    exp_q.delete();
    exp_q.push_back('0);
    prev_acc = 1'b0;
    in_a = '0;
    in_b = '0;
    rst  = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) issue(mk(2'b00, 1'b0, 1'b0, 1'b1, '0, 1'b0, 32'(i * 4), $urandom, 5'd0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] old_w;
    do_reset(1'b0);
    preload();
    issue(mk(2'b00, 1'b0, 1'b0, 1'b1, '0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0));
    issue(mk(2'b11, 1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h10, 32'h0, 5'd8));
    issue(mk(2'b00, 1'b1, 1'b0, 1'b0, 32'd100, 1'b1, 32'h0, 32'h0, 5'd0));
    issue(mk(2'b00, 1'b1, 1'b0, 1'b0, 32'd200, 1'b0, 32'h0, 32'h0, 5'd0));
    issue(mk(2'b10, 1'b0, 1'b0, 1'b0, '0, 1'b0, 32'd30, 32'h55, 5'd10));
    issue(mk(2'b11, 1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h1C, 32'h0, 5'd1));
    issue(mk(2'b00, 1'b0, 1'b0, 1'b1, '0, 1'b0, 32'h13, 32'h12345678, 5'd0));
    issue(mk(2'b11, 1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h10, 32'h0, 5'd2));
    issue(mk(2'b00, 1'b0, 1'b1, 1'b1, '0, 1'b0, 32'hFFFFFC14, 32'hCAFEF00D, 5'd3));
    issue(mk(2'b11, 1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h14, 32'h0, 5'd4));
    for (int i = 0; i < 250; i++) issue(rand_instr());

    do_reset(1'b1);
    preload();
    issue(mk(2'b11, 1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h10, 32'h0, 5'd8));
    issue('0);
    old_w = model_mem[1][4];
    issue(mk(2'b00, 1'b0, 1'b0, 1'b1, '0, 1'b0, 32'h10, 32'hA5A5A5A5, 5'd0));
    @(negedge clk);
    check("stall_mid", 128'(act_stall), 128'(1));
    @(posedge clk); #1;
    model_mem[1][4] = old_w;
    do_reset(1'b1);
    issue(mk(2'b11, 1'b0, 1'b1, 1'b0, '0, 1'b0, 32'h10, 32'h0, 5'd9));
    for (int i = 0; i < 120; i++) issue(rand_instr());

    for (int i = 0; i < 4; i++) issue('0);
    @(negedge clk); #1;
    check("drain", 128'(exp_q.size()), 128'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
